// File: rtl/inst0_byte_pipe_pkg.sv
// Shared types and limits for the inst0_byte_pipe retiming/whitening stage.
package inst0_byte_pipe_pkg;
  localparam int BYTE_W      = 8;
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 16;
  localparam int CNT_W       = 16;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef struct packed {
    logic  vld;
    byte_t data;
  } beat_t;
endpackage

// File: rtl/inst0_byte_pipe_stage.sv
// One valid+data pipeline register; data holds its last value while the incoming beat is invalid.
module byte_pipe_stage
  import inst0_byte_pipe_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  beat_t d,
  output beat_t q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q.vld <= d.vld;
      if (d.vld) q.data <= d.data;
    end
  end
endmodule

// File: rtl/inst0_byte_pipe.sv
// Fixed-latency byte pipe with constant XOR mask; optional beat counter under BYTE_PIPE_CNT_EN.
module inst0_byte_pipe
  import inst0_byte_pipe_pkg::*;
#(
  parameter int          DATA_W   = 8,
  parameter int          LATENCY  = 2,
  parameter logic [7:0]  XOR_MASK = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic              dout_valid,
  output logic [DATA_W-1:0] dout
`ifdef BYTE_PIPE_CNT_EN
  ,
  output logic [CNT_W-1:0]  dout_cnt
`endif
);
  generate
    if (DATA_W != BYTE_W) begin : g_bad_w
      $fatal(1, "inst0_byte_pipe: DATA_W must be 8");
    end
    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_lat
      $fatal(1, "inst0_byte_pipe: LATENCY must be in 1..16");
    end else begin : g_pipe
      // pipe[0] is the combinational entry point; pipe[i+1] is stage i's register
      beat_t [LATENCY:0] pipe;

      assign pipe[0].vld  = din_valid;
      assign pipe[0].data = din ^ XOR_MASK;

      for (genvar i = 0; i < LATENCY; i++) begin : g_stg
        byte_pipe_stage u_stg (
          .clk   (clk),
          .rst_n (rst_n),
          .d     (pipe[i]),
          .q     (pipe[i+1])
        );
      end

      assign dout_valid = pipe[LATENCY].vld;
      assign dout       = pipe[LATENCY].data;
    end
  endgenerate

`ifdef BYTE_PIPE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          dout_cnt <= '0;
    else if (dout_valid) dout_cnt <= dout_cnt + CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_inst0_byte_pipe.sv
// Randomized bench for inst0_byte_pipe: three configurations driven in parallel against a history-based model.
module tb_inst0_byte_pipe;
  localparam int N = 3;
  localparam int         LAT  [N] = '{1, 3, 4};
  localparam logic [7:0] MASK [N] = '{8'h00, 8'hFF, 8'h5A};

  typedef struct {
    logic       v;
    logic [7:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic [N-1:0] dv;
  logic [N-1:0][7:0] dq;
  logic [N-1:0][15:0] dc;
  logic [15:0] cnt_m [N];

  beat_t hist[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst0_byte_pipe #(.DATA_W(8), .LATENCY(1), .XOR_MASK(8'h00)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
    .dout_valid(dv[0]), .dout(dq[0])
`ifdef BYTE_PIPE_CNT_EN
    , .dout_cnt(dc[0])
`endif
  );
  inst0_byte_pipe #(.DATA_W(8), .LATENCY(3), .XOR_MASK(8'hFF)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
    .dout_valid(dv[1]), .dout(dq[1])
`ifdef BYTE_PIPE_CNT_EN
    , .dout_cnt(dc[1])
`endif
  );
  inst0_byte_pipe #(.DATA_W(8), .LATENCY(4), .XOR_MASK(8'h5A)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
    .dout_valid(dv[2]), .dout(dq[2])
`ifdef BYTE_PIPE_CNT_EN
    , .dout_cnt(dc[2])
`endif
  );

`ifndef BYTE_PIPE_CNT_EN
  assign dc = '0;
`endif

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output after the latest captured edge reflects the input captured LAT-1 edges earlier;
  // the data shown is the masked value of the most recent valid input up to that point.
  function automatic void exp_out(input int L, input logic [7:0] m,
                                  output logic v, output logic [7:0] d);
    int p;
    p = hist.size() - L;
    v = 1'b0;
    d = 8'h00;
    if (p >= 0) begin
      v = hist[p].v;
      for (int i = p; i >= 0; i--) begin
        if (hist[i].v) begin
          d = hist[i].d ^ m;
          break;
        end
      end
    end
  endfunction

  task automatic check_all();
    logic       ev;
    logic [7:0] ed;
    for (int k = 0; k < N; k++) begin
      exp_out(LAT[k], MASK[k], ev, ed);
      chk($sformatf("valid%0d", k), 16'(dv[k]), 16'(ev));
      chk($sformatf("data%0d", k), 16'(dq[k]), 16'(ed));
`ifdef BYTE_PIPE_CNT_EN
      chk($sformatf("cnt%0d", k), dc[k], cnt_m[k]);
`endif
      if (rst_n && ev) cnt_m[k] = cnt_m[k] + 16'd1;
    end
  endtask

  // One cycle: check at the falling edge, drive new inputs, capture them at the rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    check_all();
    din_valid = v;
    din       = d;
    rst_n     = r;
    if (!r) begin
      hist.delete();
      for (int k = 0; k < N; k++) cnt_m[k] = 16'd0;
    end
    @(posedge clk);
    if (rst_n) hist.push_back('{v, d});
  endtask

  initial begin
    logic [7:0] gap_d [5];
    logic       gap_v [5];
    for (int k = 0; k < N; k++) cnt_m[k] = 16'd0;

    // reset held with random inputs
    for (int i = 0; i < 5; i++) step(1'($urandom), 8'($urandom), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'($urandom), 1'b1);

    // single byte, then idle to confirm dout holds
    step(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 8'($urandom), 1'b1);

    // back-to-back burst
    step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'h01, 1'b1);
    step(1'b1, 8'h02, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 8'($urandom), 1'b1);

    // gap pattern
    gap_v = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    gap_d = '{8'h11, 8'hC3, 8'h22, 8'h33, 8'h3C};
    for (int i = 0; i < 5; i++) step(gap_v[i], gap_d[i], 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 8'($urandom), 1'b1);

    // three bytes in flight, then asynchronous reset between edges
    step(1'b1, 8'h81, 1'b1);
    step(1'b1, 8'h82, 1'b1);
    step(1'b1, 8'h83, 1'b1);
    #2;
    rst_n = 1'b0;
    hist.delete();
    for (int k = 0; k < N; k++) cnt_m[k] = 16'd0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("async_valid%0d", k), 16'(dv[k]), 16'd0);
      chk($sformatf("async_data%0d", k), 16'(dq[k]), 16'd0);
    end
    step(1'b1, 8'($urandom), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'($urandom), 1'b1);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 2) != 0), 8'($urandom), ($urandom_range(0, 60) != 0));
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 8'($urandom), 1'b1);

`ifdef BYTE_PIPE_CNT_EN
    // counter wrap: 65535 beats preload, then a few more
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 65535 + 2; i++) step(1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);
`endif

    @(negedge clk);
    check_all();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
